// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller and datapath.
// Holds the opcode constants, FSM states, mux/ALU select encodings and the
// control-word layout produced by the state decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
    } state_t;

    localparam logic [1:0] ALU_B_REG    = 2'd0;
    localparam logic [1:0] ALU_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write_en;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath bundle.
// master (controller): takes opcode/mem_ready, drives every enable and mux select.
// slave (datapath): the mirror view.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write_en;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write_en, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write_en, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational state -> control-word mapping.
// Ports: state (current FSM state), mem_ready (memory handshake, only used in
// S_FETCH to gate IR/PC loads), ctrl (full control word, zero when unlisted).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                // IR and PC only advance when the instruction word is actually back
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = ALU_B_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.mem_to_reg   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.reg_dst      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_src        = PC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write_en = 1'b1;
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Ports: clk, rst_n (async active-low), bus (master view: opcode/mem_ready in,
// all datapath enables and selects plus illegal_op out), state_o (debug state).
// ILLEGAL_TRAP=1 parks in S_TRAP on an unsupported opcode; 0 flags and refetches.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int STATE_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus,
    output logic [STATE_W-1:0]    state_o
);
    state_t state, state_next;
    ctrl_t  ctrl;
    logic   illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        illegal    = 1'b0;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_TRAP:   state_next = S_TRAP;
            // writeback/branch/jump and unused encodings all fall back to fetch
            default:  state_next = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write_en  = ctrl.reg_write_en;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.illegal_op    = illegal;
    assign state_o           = STATE_W'(state);
endmodule
